// File: rtl/cache_arb_pkg.sv
// Shared types and default widths for the I/D-cache memory-port arbiter.
package cache_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int LINE_W_DEF = 256;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SERVE_I,
        S_SERVE_D,
        S_RELEASE
    } arb_state_t;

    typedef enum logic {
        GNT_I,
        GNT_D
    } grant_t;

endpackage

// File: rtl/arb_grant_sel.sv
// Combinational grant decision between the I-cache and D-cache requests.
// ARB_RR_EN selects round-robin on ties; otherwise D always beats I.
module arb_grant_sel
    import cache_arb_pkg::*;
(
    input  logic   i_req_i,
    input  logic   d_req_i,
`ifdef ARB_RR_EN
    input  grant_t last_grant_i,
`endif
    output logic   any_req_o,
    output grant_t grant_o
);

    always_comb begin
        any_req_o = i_req_i | d_req_i;
        grant_o   = GNT_I;
`ifdef ARB_RR_EN
        // On a tie, hand the port to whoever did not have it last time.
        if (i_req_i && d_req_i) begin
            grant_o = (last_grant_i == GNT_I) ? GNT_D : GNT_I;
        end else if (d_req_i) begin
            grant_o = GNT_D;
        end
`else
        if (d_req_i) begin
            grant_o = GNT_D;
        end
`endif
    end

endmodule

// File: rtl/cache_arbiter.sv
// Shares the single physical-memory port between the I-cache and D-cache miss paths.
// Define ARB_RR_EN for round-robin arbitration; the default build uses fixed D-over-I priority.
module cache_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    arb_state_t state_q, state_d;
    logic       d_req;
    logic       any_req;
    grant_t     grant;

`ifdef ARB_RR_EN
    grant_t     last_grant_q, last_grant_d;
`endif

    assign d_req = d_read | d_write;

    arb_grant_sel u_grant_sel (
        .i_req_i      (i_read),
        .d_req_i      (d_req),
`ifdef ARB_RR_EN
        .last_grant_i (last_grant_q),
`endif
        .any_req_o    (any_req),
        .grant_o      (grant)
    );

    // NOTE: non-blocking assignments keep every register update on the same edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef ARB_RR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= GNT_I;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    // Read data is a plain pass-through; the resp pulses say when it is meaningful.
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_d    = state_q;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        pmem_addr  = '0;
        pmem_wdata = '0;
        i_resp     = 1'b0;
        d_resp     = 1'b0;
`ifdef ARB_RR_EN
        last_grant_d = last_grant_q;
`endif

        // NOTE: outputs are gated by rst so an abandoned transaction can neither strobe memory nor respond while reset is held.
        if (!rst) begin
            unique case (state_q)
                S_IDLE: begin
                    if (any_req) begin
                        state_d = (grant == GNT_D) ? S_SERVE_D : S_SERVE_I;
`ifdef ARB_RR_EN
                        last_grant_d = grant;
`endif
                    end
                end

                S_SERVE_D: begin
                    pmem_read  = d_read;
                    pmem_write = d_write;
                    pmem_addr  = d_addr;
                    pmem_wdata = d_wdata;
                    if (pmem_resp) begin
                        d_resp  = 1'b1;
                        state_d = S_RELEASE;
                    end else if (!d_req) begin
                        state_d = S_IDLE;
                    end
                end

                S_SERVE_I: begin
                    pmem_read = i_read;
                    pmem_addr = i_addr;
                    if (pmem_resp) begin
                        i_resp  = 1'b1;
                        state_d = S_RELEASE;
                    end else if (!i_read) begin
                        state_d = S_IDLE;
                    end
                end

                S_RELEASE: begin
                    state_d = S_IDLE;
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // A served requester must hold its level until it sees its response.
    assert property (@(posedge clk) disable iff (rst)
        (state_q == S_SERVE_D && !pmem_resp) |-> d_req);
    assert property (@(posedge clk) disable iff (rst)
        (state_q == S_SERVE_I && !pmem_resp) |-> i_read);
    assert property (@(posedge clk) disable iff (rst)
        !(pmem_read && pmem_write));

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: cycle table, directed corner sequences and a random scoreboard run.
module tb_cache_arbiter;
    import cache_arb_pkg::*;

    localparam int AW = ADDR_W_DEF;
    localparam int LW = LINE_W_DEF;

    logic          clk        = 1'b0;
    logic          rst        = 1'b1;
    logic          i_read     = 1'b0;
    logic [AW-1:0] i_addr     = '0;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read     = 1'b0;
    logic          d_write    = 1'b0;
    logic [AW-1:0] d_addr     = '0;
    logic [LW-1:0] d_wdata    = '0;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_addr;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata = '0;
    logic          pmem_resp  = 1'b0;

    always #5 clk = ~clk;

    cache_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_read     (i_read),
        .i_addr     (i_addr),
        .i_rdata    (i_rdata),
        .i_resp     (i_resp),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_resp     (d_resp),
        .pmem_read  (pmem_read),
        .pmem_write (pmem_write),
        .pmem_addr  (pmem_addr),
        .pmem_wdata (pmem_wdata),
        .pmem_rdata (pmem_rdata),
        .pmem_resp  (pmem_resp)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkl(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change right after the falling edge; outputs are read 1 time unit later.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic zero_inputs();
        i_read    = 1'b0;
        d_read    = 1'b0;
        d_write   = 1'b0;
        pmem_resp = 1'b0;
    endtask

    task automatic do_reset();
        cyc();
        rst = 1'b1;
        zero_inputs();
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    // Memory model: written lines remembered, untouched lines derived from their address.
    logic [LW-1:0] mem_model [logic [AW-1:0]];

    function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return {8{a ^ 32'hC0DE_0000}};
    endfunction

    typedef struct {
        logic ir;
        logic dr;
        logic dw;
        logic presp;
        logic ex_pr;
        logic ex_pw;
        logic ex_ir;
        logic ex_dr;
        logic ex_ad;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] in_b, input logic [4:0] ex_b);
        vec_t v;
        v.ir    = in_b[3];
        v.dr    = in_b[2];
        v.dw    = in_b[1];
        v.presp = in_b[0];
        v.ex_pr = ex_b[4];
        v.ex_pw = ex_b[3];
        v.ex_ir = ex_b[2];
        v.ex_dr = ex_b[1];
        v.ex_ad = ex_b[0];
        return v;
    endfunction

    // Random run: two agents hold level requests until answered; memory answers after 0..4 cycles.
    task automatic run_random(input int n_cycles);
        logic          i_pend = 1'b0, d_pend = 1'b0, d_is_wr = 1'b0;
        logic          i_done = 1'b0, d_done = 1'b0;
        logic [AW-1:0] ia = '0, da = 32'h8000_0000;
        logic [LW-1:0] dwd = '0;
        int            i_wait = 0, d_wait = 0;
        logic          mem_busy = 1'b0, own_d = 1'b0, m_wr = 1'b0;
        int            mem_cnt = 0;
        logic [AW-1:0] m_addr = '0;
        logic [LW-1:0] m_wdata = '0;
        logic          prev_strobe = 1'b0, prev_i = 1'b0, prev_d = 1'b0;
        logic          last_was_d = 1'b0;
        logic          strobe, exp_d;
        int            last_resp_cyc = -100;
        logic          abort = 1'b0;

        for (int c = 0; c < n_cycles && !abort; c++) begin
            cyc();
            if (i_done) begin
                i_pend = 1'b0;
                i_done = 1'b0;
            end else if (!i_pend && $urandom_range(0, 3) == 0) begin
                i_pend = 1'b1;
                ia     = 32'($urandom_range(0, 31)) << 5;
                i_wait = 0;
            end
            if (d_done) begin
                d_pend = 1'b0;
                d_done = 1'b0;
            end else if (!d_pend && $urandom_range(0, 3) == 0) begin
                d_pend  = 1'b1;
                d_is_wr = 1'($urandom_range(0, 1));
                da      = 32'h8000_0000 | (32'($urandom_range(0, 31)) << 5);
                for (int k = 0; k < 8; k++) dwd[k*32 +: 32] = $urandom;
                d_wait  = 0;
            end
            i_read  = i_pend;
            i_addr  = ia;
            d_read  = d_pend && !d_is_wr;
            d_write = d_pend && d_is_wr;
            d_addr  = da;
            d_wdata = dwd;

            pmem_resp  = 1'b0;
            pmem_rdata = {8{32'hDEAD_BEEF}};
            if (mem_busy) begin
                if (mem_cnt == 0) begin
                    pmem_resp  = 1'b1;
                    pmem_rdata = line_of(m_addr);
                end else begin
                    mem_cnt--;
                end
            end
            #1;

            strobe = pmem_read | pmem_write;
            check1("rnd_rw_excl", pmem_read & pmem_write, 1'b0);
            check1("rnd_resp_excl", i_resp & d_resp, 1'b0);

            if (strobe && !prev_strobe) begin
`ifdef ARB_RR_EN
                exp_d = prev_d && !(prev_i && last_was_d);
`else
                exp_d = prev_d;
`endif
                check1("rnd_grant_has_req", prev_i | prev_d, 1'b1);
                check1("rnd_grant_owner", pmem_write | pmem_addr[31], exp_d);
                check1("rnd_grant_spacing", (c - last_resp_cyc) >= 3, 1'b1);
                check32("rnd_grant_addr", pmem_addr, exp_d ? da : ia);
                checkl("rnd_grant_wdata", pmem_wdata, exp_d ? dwd : '0);
                check1("rnd_grant_wr", pmem_write, exp_d && d_is_wr);
                mem_busy   = 1'b1;
                mem_cnt    = int'($urandom_range(0, 4));
                own_d      = exp_d;
                m_addr     = pmem_addr;
                m_wr       = pmem_write;
                m_wdata    = pmem_wdata;
                last_was_d = exp_d;
            end

            if (pmem_resp) begin
                check1("rnd_resp_i", i_resp, !own_d);
                check1("rnd_resp_d", d_resp, own_d);
                if (m_wr) mem_model[m_addr] = m_wdata;
                if (own_d) begin
                    if (d_is_wr) checkl("rnd_wb_data", line_of(da), dwd);
                    else         checkl("rnd_d_rdata", d_rdata, line_of(da));
                    d_done = 1'b1;
                end else begin
                    checkl("rnd_i_rdata", i_rdata, line_of(ia));
                    i_done = 1'b1;
                end
                mem_busy      = 1'b0;
                last_resp_cyc = c;
            end else begin
                check1("rnd_no_resp", i_resp | d_resp, 1'b0);
            end

            prev_strobe = strobe;
            prev_i      = i_read;
            prev_d      = d_read | d_write;

            if (i_pend && !i_done) i_wait++;
            if (d_pend && !d_done) d_wait++;
            if (i_wait > 200 || d_wait > 200) begin
                check1("rnd_wait_bound", 1'(i_wait <= 200 && d_wait <= 200), 1'b1);
                abort = 1'b1;
            end
        end
        cyc();
        zero_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          tbl [14];
        logic [LW-1:0] line_a5, line_1234;
        logic          strobe_e, second_is_d, owner_d, exp_d;
        int            w;

        line_a5   = {32{8'hA5}};
        line_1234 = {16{16'h1234}};

        // Reset held two cycles with a D read already present.
        d_read = 1'b1;
        d_addr = 32'h0000_2000;
        for (int k = 0; k < 2; k++) begin
            cyc();
            #1;
            check1($sformatf("rst%0d_no_rd", k), pmem_read, 1'b0);
            check1($sformatf("rst%0d_no_wr", k), pmem_write, 1'b0);
            check32($sformatf("rst%0d_addr", k), pmem_addr, '0);
            checkl($sformatf("rst%0d_wdata", k), pmem_wdata, '0);
            check1($sformatf("rst%0d_resp", k), i_resp | d_resp, 1'b0);
        end
        cyc(); rst = 1'b0; #1;
        check1("rel1_no_rd", pmem_read, 1'b0);
        cyc(); #1;
        check1("rel2_rd", pmem_read, 1'b1);
        check32("rel2_addr", pmem_addr, 32'h0000_2000);
        cyc(); pmem_resp = 1'b1; pmem_rdata = line_a5; #1;
        check1("rel_dresp", d_resp, 1'b1);
        cyc(); pmem_resp = 1'b0; d_read = 1'b0; #1;
        cyc();

        // Cycle table: D/I tie, release spacing, spurious resp, a D write-back.
        tbl[0]  = mk(4'b1100, 5'b00000);
        tbl[1]  = mk(4'b1100, 5'b10001);
        tbl[2]  = mk(4'b1101, 5'b10011);
        tbl[3]  = mk(4'b1000, 5'b00000);
        tbl[4]  = mk(4'b1000, 5'b00000);
        tbl[5]  = mk(4'b1000, 5'b10000);
        tbl[6]  = mk(4'b1001, 5'b10100);
        tbl[7]  = mk(4'b0000, 5'b00000);
        tbl[8]  = mk(4'b0001, 5'b00000);
        tbl[9]  = mk(4'b0010, 5'b00000);
        tbl[10] = mk(4'b0010, 5'b01001);
        tbl[11] = mk(4'b0011, 5'b01011);
        tbl[12] = mk(4'b0001, 5'b00000);
        tbl[13] = mk(4'b0000, 5'b00000);

        do_reset();
        i_addr     = 32'h0000_1040;
        d_addr     = 32'h8000_0000;
        d_wdata    = line_1234;
        pmem_rdata = line_a5;
        for (int k = 0; k < 14; k++) begin
            cyc();
            i_read    = tbl[k].ir;
            d_read    = tbl[k].dr;
            d_write   = tbl[k].dw;
            pmem_resp = tbl[k].presp;
            #1;
            strobe_e = tbl[k].ex_pr | tbl[k].ex_pw;
            check1($sformatf("v%0d_pr", k), pmem_read, tbl[k].ex_pr);
            check1($sformatf("v%0d_pw", k), pmem_write, tbl[k].ex_pw);
            check1($sformatf("v%0d_iresp", k), i_resp, tbl[k].ex_ir);
            check1($sformatf("v%0d_dresp", k), d_resp, tbl[k].ex_dr);
            check32($sformatf("v%0d_addr", k), pmem_addr,
                    !strobe_e ? 32'h0 : (tbl[k].ex_ad ? 32'h8000_0000 : 32'h0000_1040));
            checkl($sformatf("v%0d_wdata", k), pmem_wdata,
                   (strobe_e && tbl[k].ex_ad) ? line_1234 : '0);
            if (tbl[k].ex_ir) checkl($sformatf("v%0d_irdata", k), i_rdata, line_a5);
            if (tbl[k].ex_dr) checkl($sformatf("v%0d_drdata", k), d_rdata, line_a5);
        end

        // Lone I read answered after 5 strobe cycles.
        cyc(); i_read = 1'b1; i_addr = 32'h0000_1040; pmem_resp = 1'b0; #1;
        check1("li_idle", pmem_read, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            cyc(); pmem_resp = (k == 6); #1;
            check1($sformatf("li%0d_pr", k), pmem_read, 1'b1);
            check32($sformatf("li%0d_addr", k), pmem_addr, 32'h0000_1040);
            check1($sformatf("li%0d_iresp", k), i_resp, k == 6);
            check1($sformatf("li%0d_dresp", k), d_resp, 1'b0);
            if (k == 6) checkl("li_irdata", i_rdata, line_a5);
        end
        cyc(); pmem_resp = 1'b0; i_read = 1'b0; #1;
        check1("li_after_pr", pmem_read, 1'b0);
        check1("li_after_iresp", i_resp, 1'b0);
        cyc();

        // Write-back then refill while the I-cache waits.
`ifdef ARB_RR_EN
        second_is_d = 1'b0;
`else
        second_is_d = 1'b1;
`endif
        do_reset();
        cyc();
        i_read = 1'b1; i_addr = 32'h0000_1040;
        d_write = 1'b1; d_addr = 32'h0000_2000; d_wdata = line_1234; #1;
        check1("wb_idle", pmem_write | pmem_read, 1'b0);
        cyc(); #1;
        check1("wb_pw", pmem_write, 1'b1);
        check1("wb_pr", pmem_read, 1'b0);
        check32("wb_addr", pmem_addr, 32'h0000_2000);
        checkl("wb_wdata", pmem_wdata, line_1234);
        cyc(); pmem_resp = 1'b1; #1;
        check1("wb_dresp", d_resp, 1'b1);
        check1("wb_iresp", i_resp, 1'b0);
        cyc(); pmem_resp = 1'b0; d_write = 1'b0; d_read = 1'b1; d_addr = 32'h0000_3000; #1;
        check1("wb_release", pmem_read | pmem_write, 1'b0);
        cyc(); #1;
        check1("wb_idle2", pmem_read, 1'b0);
        cyc(); #1;
        check1("rf1_pr", pmem_read, 1'b1);
        check32("rf1_addr", pmem_addr, second_is_d ? 32'h0000_3000 : 32'h0000_1040);
        cyc(); pmem_resp = 1'b1; #1;
        check1("rf1_dresp", d_resp, second_is_d);
        check1("rf1_iresp", i_resp, !second_is_d);
        cyc(); pmem_resp = 1'b0;
        if (second_is_d) d_read = 1'b0;
        else             i_read = 1'b0;
        cyc();
        cyc(); #1;
        check1("rf2_pr", pmem_read, 1'b1);
        check32("rf2_addr", pmem_addr, second_is_d ? 32'h0000_1040 : 32'h0000_3000);
        cyc(); pmem_resp = 1'b1; #1;
        check1("rf2_dresp", d_resp, !second_is_d);
        check1("rf2_iresp", i_resp, second_is_d);
        cyc(); zero_inputs();
        cyc();

        // Four back-to-back ties: D,I,D,I with round-robin, D every time otherwise.
        do_reset();
        i_addr = 32'h0000_1040;
        d_addr = 32'h8000_0000;
        for (int r = 0; r < 4; r++) begin
            w = 0;
            do begin
                cyc(); pmem_resp = 1'b0; i_read = 1'b1; d_read = 1'b1; #1;
                w++;
            end while (!pmem_read && w < 8);
            check1($sformatf("rr%0d_strobe", r), pmem_read, 1'b1);
`ifdef ARB_RR_EN
            exp_d = (r % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            owner_d = (pmem_addr == 32'h8000_0000);
            check1($sformatf("rr%0d_owner", r), owner_d, exp_d);
            cyc(); pmem_resp = 1'b1; #1;
            check1($sformatf("rr%0d_dresp", r), d_resp, exp_d);
            check1($sformatf("rr%0d_iresp", r), i_resp, !exp_d);
            cyc(); pmem_resp = 1'b0;
            if (owner_d) d_read = 1'b0;
            else         i_read = 1'b0;
        end
        cyc(); zero_inputs();
        cyc();

        // Reset while the I-cache is being served, with memory answering in the reset cycle.
        do_reset();
        cyc(); i_read = 1'b1; i_addr = 32'h0000_1040; #1;
        cyc(); #1;
        check1("mr_serving", pmem_read, 1'b1);
        cyc(); rst = 1'b1; i_read = 1'b0; pmem_resp = 1'b1; #1;
        check1("mr_rst_iresp", i_resp, 1'b0);
        check1("mr_rst_pr", pmem_read, 1'b0);
        cyc(); rst = 1'b0; pmem_resp = 1'b0; #1;
        check1("mr_after_pr", pmem_read, 1'b0);
        check1("mr_after_iresp", i_resp, 1'b0);
        check32("mr_state", 32'(dut.state_q), 32'(S_IDLE));
        cyc(); pmem_resp = 1'b1; #1;
        check1("mr_idle_ignore", i_resp | d_resp, 1'b0);
        cyc(); pmem_resp = 1'b0;

        do_reset();
        run_random(3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
